// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the PC, keeps one imem read in flight
// and holds one returned instruction for decode, squashing stale fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_noBranch,
    input  logic [31:0] pc_Branch,
    input  logic        branch_taken,
    output logic [31:0] PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        FLUSH
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;

    logic space;
    logic grant;

    assign space    = !valid_q || instr_ready;
    assign imem_req = (state_q == FETCH) && space;
    assign grant    = imem_req && imem_gnt;

    assign PC          = pc_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q && !instr_ready;
        if (branch_taken) begin
            // redirect wins: drop the buffer and squash anything in flight
            pc_d    = pc_Branch;
            valid_d = 1'b0;
            case (state_q)
                FETCH:   state_d = grant ? FLUSH : FETCH;
                WAIT:    state_d = imem_rvalid ? FETCH : FLUSH;
                FLUSH:   state_d = imem_rvalid ? FETCH : FLUSH;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (grant) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_noBranch;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_d    = imem_rdata;
                        instr_pc_d = req_pc_q;
                        valid_d    = 1'b1;
                        state_d    = FETCH;
                    end
                end
                FLUSH: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem with configurable grant delay and
// latency, expected words queued up front and checked at each handshake.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_noBranch;
    logic [31:0] pc_Branch;
    logic        branch_taken;
    logic [31:0] PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_noBranch (pc_noBranch),
        .pc_Branch   (pc_Branch),
        .branch_taken(branch_taken),
        .PC          (PC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    assign pc_noBranch = PC + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int lat;
        int gdly;
        int nw;
        int first;
        int period;
    } row_t;

    int n_pass  = 0;
    int n_total = 0;

    exp_t        sb[$];
    logic [31:0] gq[$];
    int          dcyc[$];

    int          lat, gdly, cnt, req_wait, cyc, n_deliv, n_grant;
    bit          busy, prev_wait, prev_br, last_g, last_rv;
    logic [31:0] pend, prev_addr;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.data = a ^ KEY;
        sb.push_back(e);
    endtask

    task automatic model_clear();
        busy      = 1'b0;
        cnt       = 0;
        req_wait  = 0;
        cyc       = 0;
        n_deliv   = 0;
        n_grant   = 0;
        prev_wait = 1'b0;
        prev_br   = 1'b0;
        pend      = 32'h0;
        prev_addr = 32'h0;
        sb.delete();
        gq.delete();
        dcyc.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_pc", PC, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        branch_taken = 1'b0;
        pc_Branch    = 32'h0;
        instr_ready  = 1'b1;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic tick();
        bit          g, rv, hs, rq;
        logic [31:0] a;
        exp_t        e;
        #3;
        imem_rvalid = busy && (cnt == 0);
        imem_rdata  = imem_rvalid ? (pend ^ KEY) : 32'hDEAD_BEEF;
        imem_gnt    = (req_wait >= gdly);
        #1;
        rq = imem_req;
        a  = imem_addr;
        g  = imem_req && imem_gnt;
        rv = imem_rvalid;
        hs = instr_valid && instr_ready;
        if (g) begin
            chk("one_outstanding", {31'h0, busy}, 32'h0);
            gq.push_back(a);
            n_grant++;
        end
        if (prev_wait && rq && !prev_br)
            chk("addr_held", a, prev_addr);
        if (hs) begin
            chk("sb_nonempty", {31'h0, sb.size() != 0}, 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("instr_pc", instr_pc, e.pc);
                chk("instr", instr, e.data);
            end
            dcyc.push_back(cyc);
            n_deliv++;
        end
        prev_wait = rq && !g;
        prev_addr = a;
        prev_br   = branch_taken;
        last_g    = g;
        last_rv   = rv;
        @(posedge clk);
        #1;
        if (rv) busy = 1'b0;
        if (g) begin
            busy     = 1'b1;
            cnt      = lat - 1;
            pend     = a;
            req_wait = 0;
        end else begin
            if (busy && cnt > 0) cnt--;
            req_wait = rq ? req_wait + 1 : 0;
        end
        cyc++;
    endtask

    task automatic run_until(input int target, input int budget);
        int k = 0;
        while (n_deliv < target && k < budget) begin
            tick();
            k++;
        end
        chk("deliv_timeout", 32'(n_deliv), 32'(target));
    endtask

    row_t        rows[4];
    logic [31:0] s_instr, s_pc;
    int          g0;

    initial begin
        rows[0] = '{lat: 1, gdly: 0, nw: 4, first: 3, period: 2};
        rows[1] = '{lat: 2, gdly: 0, nw: 3, first: 4, period: 3};
        rows[2] = '{lat: 4, gdly: 3, nw: 3, first: 9, period: 8};
        rows[3] = '{lat: 1, gdly: 2, nw: 3, first: 5, period: 4};

        rst          = 1'b0;
        branch_taken = 1'b0;
        pc_Branch    = 32'h0;
        instr_ready  = 1'b1;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        lat          = 1;
        gdly         = 0;
        model_clear();

        // sequential fetch under several memory timings
        for (int r = 0; r < 4; r++) begin
            do_reset();
            lat  = rows[r].lat;
            gdly = rows[r].gdly;
            for (int i = 0; i < rows[r].nw; i++) push_exp(32'(i * 4));
            run_until(rows[r].nw, 200);
            if (dcyc.size() > 0)
                chk("first_valid_cycle", 32'(dcyc[0]), 32'(rows[r].first));
            for (int i = 1; i < dcyc.size(); i++)
                chk("valid_period", 32'(dcyc[i] - dcyc[i-1]),
                    32'(rows[r].period));
            chk("sb_drained", 32'(sb.size()), 32'h0);
        end

        // backpressure on the first word
        do_reset();
        lat = 1;
        gdly = 0;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        for (int k = 0; k < 20 && !instr_valid; k++) tick();
        chk("bp_valid", {31'h0, instr_valid}, 32'h1);
        s_instr = instr;
        s_pc    = instr_pc;
        g0      = n_grant;
        repeat (5) begin
            tick();
            chk("bp_hold_valid", {31'h0, instr_valid}, 32'h1);
            chk("bp_hold_instr", instr, s_instr);
            chk("bp_hold_pc", instr_pc, s_pc);
        end
        chk("bp_grants", {31'h0, (n_grant - g0) <= 1}, 32'h1);
        instr_ready = 1'b1;
        run_until(4, 60);
        chk("bp_drained", 32'(sb.size()), 32'h0);

        // redirect while waiting on memory
        do_reset();
        lat = 3;
        gdly = 0;
        tick();
        tick();
        branch_taken = 1'b1;
        pc_Branch    = 32'h100;
        push_exp(32'h100);
        push_exp(32'h104);
        tick();
        branch_taken = 1'b0;
        chk("br_wait_pc", PC, 32'h100);
        run_until(2, 60);
        chk("br_wait_refetch", gq.size() > 1 ? gq[1] : 32'hFFFF_FFFF,
            32'h100);
        chk("br_wait_drained", 32'(sb.size()), 32'h0);

        // redirect in the grant cycle
        do_reset();
        lat = 1;
        gdly = 0;
        tick();
        branch_taken = 1'b1;
        pc_Branch    = 32'h200;
        push_exp(32'h200);
        tick();
        branch_taken = 1'b0;
        chk("br_gnt_same_cycle", {31'h0, last_g}, 32'h1);
        run_until(1, 40);
        chk("br_gnt_refetch", gq.size() > 1 ? gq[1] : 32'hFFFF_FFFF,
            32'h200);

        // redirect in the response cycle
        do_reset();
        lat = 2;
        gdly = 0;
        repeat (3) tick();
        branch_taken = 1'b1;
        pc_Branch    = 32'h300;
        push_exp(32'h300);
        tick();
        branch_taken = 1'b0;
        chk("br_rv_same_cycle", {31'h0, last_rv}, 32'h1);
        chk("br_rv_no_valid", {31'h0, instr_valid}, 32'h0);
        run_until(1, 40);
        chk("br_rv_refetch", gq.size() > 1 ? gq[1] : 32'hFFFF_FFFF,
            32'h300);

        // async reset during WAIT with a stray response after release
        do_reset();
        lat = 4;
        gdly = 0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        busy = 1'b1;
        cnt  = 0;
        pend = 32'h0BAD_0000;
        push_exp(32'h0);
        tick();
        chk("stray_rvalid_seen", {31'h0, last_rv}, 32'h1);
        chk("stray_ignored", {31'h0, instr_valid}, 32'h0);
        run_until(1, 40);
        chk("post_rst_fetch", gq.size() > 0 ? gq[0] : 32'hFFFF_FFFF,
            32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
